dps_timer_responder: RTL and testbench

DPS_TIMER_RESPONDER -- requirements
Module: dps_timer_responder

---
 rtl/dps_timer_responder.sv | 183 ++++++++++++++++++
 tb/tb_dps_timer_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dps_timer_responder.sv
// dps_timer_responder
//   Memory-mapped timer peripheral on a request/response bus.
//   It holds a free-running 32-bit counter with a compare register. A match
//   sets a sticky status bit, can reload the counter to zero, and can raise
//   an interrupt that stays pending until it is acknowledged.
//
//   State | Meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no interrupt outstanding; a match with IRQ_EN set raises one
//   PEND  | interrupt raised; oDPS_IRQ_REQ=1 until iDPS_IRQ_ACK
//
// Ports
//   iCLOCK, iRESET_SYNC          clock and synchronous active-high reset
//   iDPS_REQ/oDPS_BUSY           request valid / request stall
//   iDPS_RW, iDPS_ADDR, iDPS_DATA  read(0)/write(1), byte address, write data
//   oDPS_REQ/iDPS_BUSY           read response valid / response backpressure
//   oDPS_DATA                    read response data
//   oDPS_IRQ_REQ, oDPS_IRQ_NUM   interrupt level and fixed interrupt number
//   iDPS_IRQ_ACK                 interrupt acknowledge pulse
//
// Register map (iDPS_ADDR[7:2], upper address bits must be zero)
//   0x00 ID  0x04 SIZE  0x08 CTRL{AUTO_RELOAD,IRQ_EN,EN}
//   0x0C COUNTER  0x10 COMPARE  0x14 STATUS{MATCH, write-1-to-clear}
module dps_timer_responder #(
    parameter logic [31:0] P_DEV_ID  = 32'h0000_0D50,
    parameter logic [31:0] P_IO_SIZE = 32'h0000_0200,
    parameter logic [5:0]  P_IRQ_NUM = 6'h1
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iDPS_REQ,
    output logic        oDPS_BUSY,
    input  logic        iDPS_RW,
    input  logic [31:0] iDPS_ADDR,
    input  logic [31:0] iDPS_DATA,
    output logic        oDPS_REQ,
    input  logic        iDPS_BUSY,
    output logic [31:0] oDPS_DATA,
    output logic        oDPS_IRQ_REQ,
    output logic [5:0]  oDPS_IRQ_NUM,
    input  logic        iDPS_IRQ_ACK
);

    localparam logic [5:0] A_ID      = 6'h00;
    localparam logic [5:0] A_SIZE    = 6'h01;
    localparam logic [5:0] A_CTRL    = 6'h02;
    localparam logic [5:0] A_COUNTER = 6'h03;
    localparam logic [5:0] A_COMPARE = 6'h04;
    localparam logic [5:0] A_STATUS  = 6'h05;

    typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} irq_state_t;

    logic [2:0]  ctrl;
    logic [31:0] counter;
    logic [31:0] compare;
    logic        match;

    logic [31:0] fifo_mem [2];
    logic        fifo_wr_ptr;
    logic        fifo_rd_ptr;
    logic [1:0]  fifo_count;

    irq_state_t  irq_state;
    irq_state_t  irq_state_next;

    logic        accept;
    logic        wr_en;
    logic        rd_en;
    logic        addr_ok;
    logic [5:0]  word;
    logic [31:0] rd_value;
    logic        push;
    logic        pop;
    logic        match_evt;
    logic        unused_addr_bits;

    // Byte-lane bits carry no meaning for word registers.
    assign unused_addr_bits = ^iDPS_ADDR[1:0];

    assign word    = iDPS_ADDR[7:2];
    assign addr_ok = (iDPS_ADDR[31:8] == 24'd0);
    assign accept  = iDPS_REQ && !oDPS_BUSY;
    assign wr_en   = accept && iDPS_RW && addr_ok;
    assign rd_en   = accept && !iDPS_RW;

    assign match_evt = ctrl[0] && (counter == compare);

    always_comb begin
        rd_value = 32'd0;
        if (addr_ok) begin
            case (word)
                A_ID:      rd_value = P_DEV_ID;
                A_SIZE:    rd_value = P_IO_SIZE;
                A_CTRL:    rd_value = {29'd0, ctrl};
                A_COUNTER: rd_value = counter;
                A_COMPARE: rd_value = compare;
                A_STATUS:  rd_value = {31'd0, match};
                default:   rd_value = 32'd0;
            endcase
        end
    end

    // Register file and timer
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            ctrl    <= 3'd0;
            counter <= 32'd0;
            compare <= 32'd0;
            match   <= 1'b0;
        end else begin
            if (wr_en && word == A_CTRL)
                ctrl <= iDPS_DATA[2:0];
            if (wr_en && word == A_COMPARE)
                compare <= iDPS_DATA;

            // Software write beats both reload and increment.
            if (wr_en && word == A_COUNTER)
                counter <= iDPS_DATA;
            else if (match_evt && ctrl[2])
                counter <= 32'd0;
            else if (ctrl[0])
                counter <= counter + 32'd1;

            // A match in the same cycle as a clear wins.
            if (match_evt)
                match <= 1'b1;
            else if (wr_en && word == A_STATUS && iDPS_DATA[0])
                match <= 1'b0;
        end
    end

    // Two-entry response FIFO; oDPS_BUSY when full keeps pushes legal.
    assign push      = rd_en;
    assign pop       = oDPS_REQ && !iDPS_BUSY;
    assign oDPS_REQ  = (fifo_count != 2'd0);
    assign oDPS_BUSY = (fifo_count == 2'd2);
    assign oDPS_DATA = oDPS_REQ ? fifo_mem[fifo_rd_ptr] : 32'd0;

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_count  <= 2'd0;
            fifo_mem[0] <= 32'd0;
            fifo_mem[1] <= 32'd0;
        end else begin
            if (push) begin
                fifo_mem[fifo_wr_ptr] <= rd_value;
                fifo_wr_ptr           <= ~fifo_wr_ptr;
            end
            if (pop)
                fifo_rd_ptr <= ~fifo_rd_ptr;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Interrupt FSM
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC)
            irq_state <= ST_IDLE;
        else
            irq_state <= irq_state_next;
    end

    always_comb begin
        irq_state_next = irq_state;
        case (irq_state)
            ST_IDLE: if (match_evt && ctrl[1]) irq_state_next = ST_PEND;
            ST_PEND: if (iDPS_IRQ_ACK)         irq_state_next = ST_IDLE;
            default: irq_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        oDPS_IRQ_REQ = (irq_state == ST_PEND);
        oDPS_IRQ_NUM = P_IRQ_NUM;
    end

endmodule

// File: tb/tb_dps_timer_responder.sv
// Bench for dps_timer_responder: directed scenarios followed by random
// traffic, all checked each cycle against a behavioural register/queue model.
module tb_dps_timer_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_busy;
    logic        ack;
    logic        dut_busy;
    logic        dut_req;
    logic [31:0] dut_data;
    logic        dut_irq;
    logic [5:0]  dut_irq_num;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dps_timer_responder dut (
        .iCLOCK       (clk),
        .iRESET_SYNC  (rst),
        .iDPS_REQ     (req),
        .oDPS_BUSY    (dut_busy),
        .iDPS_RW      (rw),
        .iDPS_ADDR    (addr),
        .iDPS_DATA    (wdata),
        .oDPS_REQ     (dut_req),
        .iDPS_BUSY    (rsp_busy),
        .oDPS_DATA    (dut_data),
        .oDPS_IRQ_REQ (dut_irq),
        .oDPS_IRQ_NUM (dut_irq_num),
        .iDPS_IRQ_ACK (ack)
    );

    // Reference model state
    logic [2:0]  m_ctrl;
    logic [31:0] m_cnt;
    logic [31:0] m_cmp;
    logic        m_match;
    logic        m_pend;
    logic [31:0] m_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:8] != 0) return 32'd0;
        case (a[7:0] & 8'hFC)
            8'h00:   return 32'h0000_0D50;
            8'h04:   return 32'h0000_0200;
            8'h08:   return {29'd0, m_ctrl};
            8'h0C:   return m_cnt;
            8'h10:   return m_cmp;
            8'h14:   return {31'd0, m_match};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input logic r, input logic q, input logic w,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic b, input logic k);
        logic        acc;
        logic        hit;
        logic [31:0] rv;
        logic [7:0]  off;
        logic [2:0]  n_ctrl;
        logic [31:0] n_cnt;
        logic [31:0] n_cmp;
        logic        n_match;
        logic        n_pend;
        if (r) begin
            m_ctrl = 0; m_cnt = 0; m_cmp = 0; m_match = 0; m_pend = 0;
            m_q.delete();
            return;
        end
        acc = q && (m_q.size() < 2);
        rv  = m_read(a);
        off = (a[31:8] == 0) ? (a[7:0] & 8'hFC) : 8'hFF;
        hit = m_ctrl[0] && (m_cnt == m_cmp);
        n_ctrl = m_ctrl; n_cmp = m_cmp; n_match = m_match; n_pend = m_pend;
        n_cnt = m_cnt;
        if (m_ctrl[0]) n_cnt = (hit && m_ctrl[2]) ? 32'd0 : m_cnt + 32'd1;
        if (acc && w) begin
            if (off == 8'h08) n_ctrl = d[2:0];
            if (off == 8'h0C) n_cnt = d;
            if (off == 8'h10) n_cmp = d;
            if (off == 8'h14 && d[0]) n_match = 1'b0;
        end
        if (hit) n_match = 1'b1;
        if (m_pend) begin
            if (k) n_pend = 1'b0;
        end else if (hit && m_ctrl[1]) begin
            n_pend = 1'b1;
        end
        if (m_q.size() > 0 && !b) void'(m_q.pop_front());
        if (acc && !w) m_q.push_back(rv);
        m_ctrl = n_ctrl; m_cnt = n_cnt; m_cmp = n_cmp; m_match = n_match; m_pend = n_pend;
    endtask

    task automatic cycle(input logic r, input logic q, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic b, input logic k);
        rst = r; req = q; rw = w; addr = a; wdata = d; rsp_busy = b; ack = k;
        model_step(r, q, w, a, d, b, k);
        @(posedge clk);
        #1;
        chk("rsp_valid", {31'd0, dut_req}, {31'd0, m_q.size() > 0});
        chk("req_stall", {31'd0, dut_busy}, {31'd0, m_q.size() == 2});
        chk("rsp_data", dut_data, (m_q.size() > 0) ? m_q[0] : 32'd0);
        chk("irq_req", {31'd0, dut_irq}, {31'd0, m_pend});
        chk("irq_num", {26'd0, dut_irq_num}, 32'd1);
    endtask

    task automatic idle(input logic b);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, b, 1'b0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cycle(1'b0, 1'b1, 1'b1, a, d, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a, input logic b);
        cycle(1'b0, 1'b1, 1'b0, a, 32'd0, b, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic        r, q, w, b, k;
        logic [31:0] a, d;
        int          sel;
        m_ctrl = 0; m_cnt = 0; m_cmp = 0; m_match = 0; m_pend = 0;
        rst = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; wdata = '0; rsp_busy = 1'b0; ack = 1'b0;

        do_reset();
        chk("reset_req", {31'd0, dut_req}, 32'd0);
        chk("reset_busy", {31'd0, dut_busy}, 32'd0);
        chk("reset_irq", {31'd0, dut_irq}, 32'd0);

        // Size query: one-cycle latency, one-cycle response
        rd(32'h04, 1'b0);
        chk("size_valid", {31'd0, dut_req}, 32'd1);
        chk("size_data", dut_data, 32'h200);
        idle(1'b0);
        chk("size_gone", {31'd0, dut_req}, 32'd0);

        // Backpressure: third read stalls, order preserved
        rd(32'h00, 1'b1);
        rd(32'h04, 1'b1);
        chk("bp_full", {31'd0, dut_busy}, 32'd1);
        chk("bp_head0", dut_data, 32'hD50);
        rd(32'h08, 1'b1);
        rd(32'h08, 1'b0);
        chk("bp_head1", dut_data, 32'h200);
        rd(32'h08, 1'b0);
        chk("bp_head2", dut_data, 32'h0);
        idle(1'b0);
        chk("bp_drained", {31'd0, dut_req}, 32'd0);

        // Match with auto-reload and IRQ
        wr(32'h10, 32'd5);
        wr(32'h0C, 32'd0);
        wr(32'h08, 32'd7);
        repeat (5) idle(1'b0);
        chk("ar_no_irq_yet", {31'd0, dut_irq}, 32'd0);
        idle(1'b0);
        chk("ar_irq", {31'd0, dut_irq}, 32'd1);
        rd(32'h0C, 1'b0);
        chk("ar_reloaded", dut_data, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("ar_acked", {31'd0, dut_irq}, 32'd0);
        wr(32'h08, 32'd0);

        // Wrap through zero without reload
        do_reset();
        wr(32'h10, 32'd1);
        wr(32'h0C, 32'hFFFF_FFFE);
        wr(32'h08, 32'd1);
        rd(32'h0C, 1'b0);
        chk("wrap_fffe", dut_data, 32'hFFFF_FFFE);
        rd(32'h0C, 1'b0);
        chk("wrap_ffff", dut_data, 32'hFFFF_FFFF);
        rd(32'h0C, 1'b0);
        chk("wrap_0", dut_data, 32'd0);
        rd(32'h0C, 1'b0);
        chk("wrap_1", dut_data, 32'd1);
        rd(32'h0C, 1'b0);
        chk("wrap_2", dut_data, 32'd2);
        rd(32'h14, 1'b0);
        chk("wrap_match", dut_data, 32'd1);

        // Clear collides with match: set wins
        do_reset();
        wr(32'h10, 32'd3);
        wr(32'h08, 32'd1);
        repeat (3) idle(1'b0);
        wr(32'h14, 32'd1);
        wr(32'h08, 32'd0);
        rd(32'h14, 1'b0);
        chk("w1c_collide", dut_data, 32'd1);
        wr(32'h14, 32'd1);
        rd(32'h14, 1'b0);
        chk("w1c_lone", dut_data, 32'd0);

        // Reset with full FIFO and pending IRQ
        do_reset();
        wr(32'h08, 32'd3);
        idle(1'b1);
        rd(32'h00, 1'b1);
        rd(32'h04, 1'b1);
        chk("pre_rst_full", {31'd0, dut_busy}, 32'd1);
        chk("pre_rst_irq", {31'd0, dut_irq}, 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 32'h08, 32'd0, 1'b0, 1'b0);
        chk("rst_req", {31'd0, dut_req}, 32'd0);
        chk("rst_busy", {31'd0, dut_busy}, 32'd0);
        chk("rst_irq", {31'd0, dut_irq}, 32'd0);
        rd(32'h08, 1'b0);
        chk("rst_ctrl", dut_data, 32'd0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            r   = ($urandom_range(0, 299) == 0);
            q   = $urandom_range(0, 1);
            w   = $urandom_range(0, 1);
            b   = ($urandom_range(0, 2) == 0);
            k   = ($urandom_range(0, 7) == 0);
            sel = $urandom_range(0, 9);
            if (sel <= 5)       a = {24'd0, sel[5:0], 2'(($urandom))};
            else if (sel == 6)  a = {24'd0, 8'(($urandom_range(6, 63)) << 2)};
            else if (sel == 7)  a = $urandom | 32'h0000_0100;
            else                a = 32'h0C;
            d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20)) : $urandom;
            cycle(r, q, w, a, d, b, k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
